// File: rtl/spi_byte_xmit.sv
// SPI-slave byte transmitter: splits meta bytes and 32-bit sample words into
// enabled bytes and shifts them MSB-first on MISO under the host's SPI clock.
module spi_byte_xmit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        extReset,
  input  logic        writeMeta,
  input  logic [7:0]  meta_data,
  input  logic        send,
  input  logic [31:0] dataIn,
  input  logic [3:0]  disabledGroups,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  output logic        byteDone,
  output logic        xmit_idle
);

  typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_WAIT} state_t;

  state_t                 state_reg;
  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic                   sclk_prev_reg;
  logic [31:0]            word_reg;
  logic [3:0]             skip_reg;
  logic [7:0]             txbyte_reg;
  logic                   txvalid_reg;
  logic [7:0]             shreg_reg;
  logic [2:0]             bitcnt_reg;
  logic                   miso_reg;
  logic                   byte_done_reg;
  logic                   idle_reg;

  logic       sclk_s;
  logic       cs_high;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       sel_found;
  logic [1:0] sel_idx;
  logic [7:0] load_byte;

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign cs_high   = cs_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_s & sclk_prev_reg;
  assign load_byte = txvalid_reg ? txbyte_reg : 8'h00;

  // Lowest-numbered byte still enabled (skip bit clear).
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!skip_reg[i]) begin
        sel_found = 1'b1;
        sel_idx   = i[1:0];
      end
    end
  end

  always_ff @(posedge clock or posedge extReset) begin
    if (extReset) begin
      state_reg     <= ST_IDLE;
      sclk_sync_reg <= '0;
      cs_sync_reg   <= '1;
      sclk_prev_reg <= 1'b0;
      word_reg      <= 32'h0;
      skip_reg      <= 4'hF;
      txbyte_reg    <= 8'h00;
      txvalid_reg   <= 1'b0;
      shreg_reg     <= 8'h00;
      bitcnt_reg    <= 3'd0;
      miso_reg      <= 1'b0;
      byte_done_reg <= 1'b0;
      idle_reg      <= 1'b1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev_reg <= sclk_s;
      byte_done_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (send) begin
            word_reg  <= dataIn;
            skip_reg  <= disabledGroups;
            state_reg <= ST_SELECT;
            idle_reg  <= 1'b0;
          end else if (writeMeta) begin
            word_reg  <= {24'h0, meta_data};
            skip_reg  <= 4'b1110;
            state_reg <= ST_SELECT;
            idle_reg  <= 1'b0;
          end
        end
        ST_SELECT: begin
          if (sel_found) begin
            txbyte_reg         <= word_reg[{sel_idx, 3'b000} +: 8];
            txvalid_reg        <= 1'b1;
            skip_reg[sel_idx]  <= 1'b1;
            state_reg          <= ST_WAIT;
          end else begin
            state_reg <= ST_IDLE;
            idle_reg  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (byte_done_reg) state_reg <= ST_SELECT;
        end
        default: state_reg <= ST_IDLE;
      endcase

      // cs_n high aborts the frame; the current byte is reloaded whole.
      if (cs_high) begin
        bitcnt_reg <= 3'd0;
        shreg_reg  <= load_byte;
      end else begin
        if (sclk_rise) begin
          bitcnt_reg <= bitcnt_reg + 3'd1;
          if (bitcnt_reg == 3'd7 && txvalid_reg) begin
            byte_done_reg <= 1'b1;
            txvalid_reg   <= 1'b0;
          end
        end
        if (bitcnt_reg == 3'd0) begin
          shreg_reg <= load_byte;
        end else if (sclk_fall) begin
          shreg_reg <= {shreg_reg[6:0], 1'b0};
        end
      end

      miso_reg <= shreg_reg[7];
    end
  end

  assign spi_miso  = miso_reg;
  assign byteDone  = byte_done_reg;
  assign xmit_idle = idle_reg;

endmodule

// File: tb/tb_spi_byte_xmit.sv
// Directed bench for spi_byte_xmit: acts as the SPI host (mode 0) and the producers.
module tb_spi_byte_xmit;

  logic        clock = 1'b0;
  logic        extReset;
  logic        writeMeta;
  logic [7:0]  meta_data;
  logic        send;
  logic [31:0] dataIn;
  logic [3:0]  disabledGroups;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_miso;
  logic        byteDone;
  logic        xmit_idle;

  int tests = 0;
  int fails = 0;

  spi_byte_xmit #(.SYNC_STAGES(2)) dut (
    .clock(clock), .extReset(extReset), .writeMeta(writeMeta), .meta_data(meta_data),
    .send(send), .dataIn(dataIn), .disabledGroups(disabledGroups),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_miso(spi_miso),
    .byteDone(byteDone), .xmit_idle(xmit_idle)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[TB] %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Host clocks n bits; MISO is sampled just before each rising edge.
  task automatic spi_bits(input int n, output logic [7:0] b, output int dones);
    b = 8'h00;
    dones = 0;
    for (int i = 0; i < n; i++) begin
      b = {b[6:0], spi_miso};
      spi_sclk = 1'b1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clock);
        if (byteDone) dones++;
      end
      spi_sclk = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clock);
        if (byteDone) dones++;
      end
    end
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp_b, input int exp_d);
    logic [7:0] b;
    int d;
    spi_bits(8, b, d);
    check({tag, " byte"}, {24'h0, b}, {24'h0, exp_b});
    check({tag, " byteDone count"}, d, exp_d);
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clock);
  endtask

  initial begin
    logic [7:0] part;
    int         pd;
    extReset = 1'b1; writeMeta = 1'b0; meta_data = 8'h00; send = 1'b0;
    dataIn = 32'h0; disabledGroups = 4'h0; spi_sclk = 1'b0; spi_cs_n = 1'b1;
    wait_cycles(3);
    check("reset miso", {31'h0, spi_miso}, 32'h0);
    check("reset byteDone", {31'h0, byteDone}, 32'h0);
    check("reset xmit_idle", {31'h0, xmit_idle}, 32'h1);
    extReset = 1'b0;
    spi_cs_n = 1'b0;
    wait_cycles(4);

    // 1: meta byte A5
    meta_data = 8'hA5; writeMeta = 1'b1;
    wait_cycles(1);
    writeMeta = 1'b0;
    check("t1 idle low after strobe", {31'h0, xmit_idle}, 32'h0);
    wait_cycles(5);
    expect_byte("t1 A5", 8'hA5, 1);
    check("t1 idle after byte", {31'h0, xmit_idle}, 32'h1);

    // 2: all four bytes
    dataIn = 32'h44332211; disabledGroups = 4'b0000; send = 1'b1;
    wait_cycles(1);
    send = 1'b0;
    check("t2 idle low after send", {31'h0, xmit_idle}, 32'h0);
    wait_cycles(5);
    expect_byte("t2 b0", 8'h11, 1);
    expect_byte("t2 b1", 8'h22, 1);
    expect_byte("t2 b2", 8'h33, 1);
    expect_byte("t2 b3", 8'h44, 1);
    check("t2 idle at end", {31'h0, xmit_idle}, 32'h1);

    // 3: bytes 0 and 2 disabled
    disabledGroups = 4'b0101; send = 1'b1;
    wait_cycles(1);
    send = 1'b0;
    wait_cycles(5);
    expect_byte("t3 b1", 8'h22, 1);
    expect_byte("t3 b3", 8'h44, 1);
    expect_byte("t3 filler", 8'h00, 0);
    check("t3 idle at end", {31'h0, xmit_idle}, 32'h1);

    // 4: all disabled, meta in the same cycle is dropped
    disabledGroups = 4'b1111; send = 1'b1; meta_data = 8'hFF; writeMeta = 1'b1;
    wait_cycles(1);
    send = 1'b0; writeMeta = 1'b0;
    check("t4 idle one cycle after", {31'h0, xmit_idle}, 32'h0);
    wait_cycles(1);
    check("t4 idle two cycles after", {31'h0, xmit_idle}, 32'h1);
    expect_byte("t4 no meta", 8'h00, 0);

    // 5: cs_n abort after 3 bits, byte re-sent whole
    meta_data = 8'hC3; writeMeta = 1'b1;
    wait_cycles(1);
    writeMeta = 1'b0;
    wait_cycles(5);
    spi_bits(3, part, pd);
    check("t5 partial bits", {24'h0, part}, 32'h6);
    check("t5 partial byteDone", pd, 0);
    spi_cs_n = 1'b1;
    wait_cycles(8);
    check("t5 idle while aborted", {31'h0, xmit_idle}, 32'h0);
    spi_cs_n = 1'b0;
    wait_cycles(8);
    expect_byte("t5 resend", 8'hC3, 1);

    // 6: reset mid-word
    dataIn = 32'h44332211; disabledGroups = 4'b0101; send = 1'b1;
    wait_cycles(1);
    send = 1'b0;
    wait_cycles(5);
    expect_byte("t6 b1", 8'h22, 1);
    wait_cycles(4);
    extReset = 1'b1;
    #1;
    check("t6 miso in reset", {31'h0, spi_miso}, 32'h0);
    check("t6 idle in reset", {31'h0, xmit_idle}, 32'h1);
    wait_cycles(2);
    extReset = 1'b0;
    wait_cycles(5);
    expect_byte("t6 after reset", 8'h00, 0);
    check("t6 idle at end", {31'h0, xmit_idle}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
